strength_net_resolver: RTL and testbench



---
 rtl/strength_net_resolver_if.sv | 31 +++
 rtl/strength_net_resolver.sv | 137 +++++++++++++
 tb/tb_strength_net_resolver.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/strength_net_resolver_if.sv
// Slot-write and resolved-net bundle for strength_net_resolver.
// The master side writes driver slots; the slave side returns the resolved net.
interface strength_net_resolver_if #(
  parameter int WIDTH = 16,
  parameter int NDRV  = 4
);
  localparam int IDW = (NDRV > 1) ? $clog2(NDRV) : 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [IDW-1:0]   wr_id;
  logic             wr_en;
  logic [2:0]       wr_str0;
  logic [2:0]       wr_str1;
  logic [WIDTH-1:0] wr_val;
  logic             out_valid;
  logic [WIDTH-1:0] out_val;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_z;
  logic             busy;

  modport master (
    output wr_valid, wr_id, wr_en, wr_str0, wr_str1, wr_val,
    input  wr_ready, out_valid, out_val, out_x, out_z, busy
  );

  modport slave (
    input  wr_valid, wr_id, wr_en, wr_str0, wr_str1, wr_val,
    output wr_ready, out_valid, out_val, out_x, out_z, busy
  );
endinterface

// File: rtl/strength_net_resolver.sv
// Registered strength resolver for a multiply-driven net: after every slot
// update, sweeps the driver slots one per cycle and publishes value/X/Z masks.
module strength_net_resolver #(
  parameter int WIDTH = 16,
  parameter int NDRV  = 4
) (
  input logic                    clk,
  input logic                    rst,
  strength_net_resolver_if.slave bus
);
  localparam int IDW = (NDRV > 1) ? $clog2(NDRV) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   idx;

  logic             slot_en  [NDRV];
  logic [2:0]       slot_s0  [NDRV];
  logic [2:0]       slot_s1  [NDRV];
  logic [WIDTH-1:0] slot_val [NDRV];

  logic [2:0]       best     [WIDTH];
  logic [WIDTH-1:0] acc_val;
  logic [WIDTH-1:0] acc_x;

  logic [2:0]       nxt_best [WIDTH];
  logic [WIDTH-1:0] nxt_val;
  logic [WIDTH-1:0] nxt_x;
  logic [WIDTH-1:0] nxt_z;

  logic             r_valid;
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_z;

  logic             last_idx;
  logic             id_ok;

  assign bus.wr_ready  = (state == IDLE);
  assign bus.busy      = (state == SWEEP);
  assign bus.out_valid = r_valid;
  assign bus.out_val   = r_val;
  assign bus.out_x     = r_x;
  assign bus.out_z     = r_z;

  assign last_idx = (int'(idx) == NDRV - 1);
  assign id_ok    = (int'(bus.wr_id) < NDRV);

  // Fold slot idx into the running per-bit strongest-driver accumulator.
  always_comb begin
    logic [2:0] s;
    logic       v;
    nxt_best = best;
    nxt_val  = acc_val;
    nxt_x    = acc_x;
    nxt_z    = '0;
    s        = '0;
    v        = 1'b0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      v = slot_val[idx][b];
      s = '0;
      if (slot_en[idx]) begin
        s = v ? slot_s1[idx] : slot_s0[idx];
      end
      if (s > best[b]) begin
        nxt_best[b] = s;
        nxt_val[b]  = v;
        nxt_x[b]    = 1'b0;
      end else if ((s == best[b]) && (s != 3'd0) && (v != acc_val[b])) begin
        nxt_x[b] = 1'b1;
      end
      nxt_z[b] = (nxt_best[b] == 3'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      acc_val <= '0;
      acc_x   <= '0;
      r_valid <= 1'b0;
      r_val   <= '0;
      r_x     <= '0;
      r_z     <= '1;
      for (int unsigned i = 0; i < NDRV; i++) begin
        slot_en[i]  <= 1'b0;
        slot_s0[i]  <= '0;
        slot_s1[i]  <= '0;
        slot_val[i] <= '0;
      end
      for (int unsigned b = 0; b < WIDTH; b++) begin
        best[b] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wr_valid) begin
            // Out-of-range ids are still consumed and still trigger a sweep.
            if (id_ok) begin
              slot_en[bus.wr_id]  <= bus.wr_en;
              slot_s0[bus.wr_id]  <= bus.wr_str0;
              slot_s1[bus.wr_id]  <= bus.wr_str1;
              slot_val[bus.wr_id] <= bus.wr_val;
            end
            for (int unsigned b = 0; b < WIDTH; b++) begin
              best[b] <= '0;
            end
            acc_val <= '0;
            acc_x   <= '0;
            idx     <= '0;
            state   <= SWEEP;
          end
        end
        SWEEP: begin
          best    <= nxt_best;
          acc_val <= nxt_val;
          acc_x   <= nxt_x;
          if (last_idx) begin
            r_z     <= nxt_z;
            r_x     <= nxt_x & ~nxt_z;
            r_val   <= nxt_val & ~nxt_x & ~nxt_z;
            r_valid <= 1'b1;
            idx     <= '0;
            state   <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_strength_net_resolver.sv
// Bench for strength_net_resolver: table of slot writes with expected resolved
// net, scoreboard queue popped on out_valid, plus backpressure and reset cases.
module tb_strength_net_resolver;
  localparam int WIDTH = 16;
  localparam int NDRV  = 4;

  typedef struct {
    logic [1:0]  id;
    logic        en;
    logic [2:0]  s0;
    logic [2:0]  s1;
    logic [15:0] val;
    logic [15:0] ev;
    logic [15:0] ex;
    logic [15:0] ez;
  } vec_t;

  typedef struct {
    logic [15:0] v;
    logic [15:0] x;
    logic [15:0] z;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  strength_net_resolver_if #(.WIDTH(WIDTH), .NDRV(NDRV)) bus();

  strength_net_resolver #(.WIDTH(WIDTH), .NDRV(NDRV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t        q[$];
  vec_t        tbl[22];
  int          n = 0;
  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  int          exp_pulses = 0;
  int          last_acc = 0;
  logic [15:0] last_v, last_x, last_z;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add(input logic [1:0] id, input logic en, input logic [2:0] s0,
                     input logic [2:0] s1, input logic [15:0] val, input logic [15:0] ev,
                     input logic [15:0] ex, input logic [15:0] ez);
    tbl[n] = '{id, en, s0, s1, val, ev, ex, ez};
    n++;
  endtask

  task automatic put(input vec_t t, input bit keep);
    bit r;
    bit done;
    exp_t e;
    done = 1'b0;
    @(negedge clk);
    bus.wr_id    = t.id;
    bus.wr_en    = t.en;
    bus.wr_str0  = t.s0;
    bus.wr_str1  = t.s1;
    bus.wr_val   = t.val;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      r = bus.wr_ready;
      @(posedge clk);
      #1;
      if (r) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept within 60 cycles");
    end else begin
      e = '{t.ev, t.ex, t.ez, cyc + NDRV};
      q.push_back(e);
      exp_pulses++;
      last_acc = cyc;
    end
    if (!keep) bus.wr_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  // Monitor: reset values, scoreboard pops on out_valid, stall/hold behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      last_v = '0;
      last_x = '0;
      last_z = '1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_wr_ready",  32'(bus.wr_ready),  32'd1);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_out_val",   32'(bus.out_val),   32'h0);
      chk("rst_out_x",     32'(bus.out_x),     32'h0);
      chk("rst_out_z",     32'(bus.out_z),     32'hFFFF);
    end else if (bus.out_valid) begin
      pulses++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("out_val",       32'(bus.out_val),  32'(e.v));
        chk("out_x",         32'(bus.out_x),    32'(e.x));
        chk("out_z",         32'(bus.out_z),    32'(e.z));
        chk("latency_cycle", 32'(cyc),          32'(e.cyc));
        chk("ready_on_pulse", 32'(bus.wr_ready), 32'd1);
        last_v = e.v;
        last_x = e.x;
        last_z = e.z;
      end
    end else if (q.size() != 0) begin
      chk("sweep_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("sweep_busy",     32'(bus.busy),     32'd1);
    end else begin
      chk("hold_val",   32'(bus.out_val),  32'(last_v));
      chk("hold_x",     32'(bus.out_x),    32'(last_x));
      chk("hold_z",     32'(bus.out_z),    32'(last_z));
      chk("idle_ready", 32'(bus.wr_ready), 32'd1);
    end
  end

  initial begin
    int a1, a2, a3, p0;
    bus.wr_valid = 1'b0;
    bus.wr_id    = '0;
    bus.wr_en    = 1'b0;
    bus.wr_str0  = '0;
    bus.wr_str1  = '0;
    bus.wr_val   = '0;

    //   id    en    s0    s1    val       exp val   exp x     exp z
    add(2'd2, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    add(2'd2, 1'b1, 3'd5, 3'd5, 16'h1234, 16'h1234, 16'h0000, 16'h0000);
    add(2'd2, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    add(2'd0, 1'b1, 3'd3, 3'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(2'd1, 1'b1, 3'd6, 3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
    add(2'd0, 1'b1, 3'd6, 3'd6, 16'h00FF, 16'h00FF, 16'hFF00, 16'h0000);
    add(2'd1, 1'b1, 3'd6, 3'd6, 16'h0F0F, 16'h000F, 16'h0FF0, 16'h0000);
    add(2'd1, 1'b1, 3'd5, 3'd5, 16'h5555, 16'h00FF, 16'h0000, 16'h0000);
    add(2'd0, 1'b1, 3'd6, 3'd3, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000);
    add(2'd3, 1'b1, 3'd7, 3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
    add(2'd2, 1'b1, 3'd7, 3'd7, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
    add(2'd2, 1'b1, 3'd7, 3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
    add(2'd3, 1'b1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
    add(2'd2, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(2'd0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h5555, 16'h0000, 16'h0000);
    add(2'd1, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    add(2'd3, 1'b1, 3'd0, 3'd6, 16'h00FF, 16'h00FF, 16'h0000, 16'hFF00);
    // back-to-back group
    add(2'd0, 1'b1, 3'd4, 3'd4, 16'hF0F0, 16'hF0FF, 16'h0000, 16'h0000);
    add(2'd1, 1'b1, 3'd4, 3'd4, 16'h0F0F, 16'h00FF, 16'hFF00, 16'h0000);
    add(2'd1, 1'b0, 3'd0, 3'd0, 16'h0000, 16'hF0FF, 16'h0000, 16'h0000);
    // killed by reset, then first sweep over cleared slots
    add(2'd2, 1'b1, 3'd6, 3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
    add(2'd0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      put(tbl[i], 1'b0);
    end
    drain();

    p0 = pulses;
    put(tbl[17], 1'b1);
    a1 = last_acc;
    put(tbl[18], 1'b1);
    a2 = last_acc;
    put(tbl[19], 1'b0);
    a3 = last_acc;
    chk("bp_spacing_1", 32'(a2 - a1), 32'(NDRV + 1));
    chk("bp_spacing_2", 32'(a3 - a2), 32'(NDRV + 1));
    drain();
    chk("bp_pulse_count", 32'(pulses - p0), 32'd3);

    put(tbl[20], 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    exp_pulses--;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_wr_ready",  32'(bus.wr_ready),  32'd1);
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    chk("midrst_out_z",     32'(bus.out_z),     32'hFFFF);
    repeat (NDRV + 2) @(negedge clk);
    #2 rst = 1'b0;
    put(tbl[21], 1'b0);
    drain();
    repeat (3) @(negedge clk);

    chk("total_pulses", 32'(pulses), 32'(exp_pulses));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
